// File: rtl/audio_stream_proc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | audio_stream_proc: rx-FIFO -> per-frame bypass/gain/mute/clip -> tx-FIFO |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module audio_stream_proc #(
  parameter int CH_WIDTH   = 16,
  parameter int NUM_CH     = 2,
  parameter int GAIN_WIDTH = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en_i,
  input  logic [1:0]                   mode_i,
  input  logic [GAIN_WIDTH-1:0]        gain_i,
  input  logic [CH_WIDTH-2:0]          clip_level_i,
  input  logic                         clip_clr_i,
  input  logic                         adcfifo_empty_i,
  output logic                         adcfifo_read_o,
  input  logic [NUM_CH*CH_WIDTH-1:0]   adcfifo_readdata_i,
  input  logic                         dacfifo_full_i,
  output logic                         dacfifo_write_o,
  output logic [NUM_CH*CH_WIDTH-1:0]   dacfifo_writedata_o,
  output logic [31:0]                  frame_cnt_o,
  output logic                         clip_flag_o,
  output logic                         busy_o
);

  localparam int FW = NUM_CH * CH_WIDTH;
  localparam int PW = CH_WIDTH + GAIN_WIDTH + 1;
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(RD_LAT - 1);
  localparam logic [1:0] MODE_GAIN = 2'd1;
  localparam logic [1:0] MODE_MUTE = 2'd2;
  localparam logic [1:0] MODE_CLIP = 2'd3;
  localparam logic signed [PW-1:0] SAT_MAX = PW'((2 ** (CH_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_CALC = 3'd3,
    S_WR   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           wait_cnt_q, wait_cnt_d;
  logic [1:0]              mode_q;
  logic [GAIN_WIDTH-1:0]   gain_q;
  logic [CH_WIDTH-2:0]     clip_lvl_q;
  logic [FW-1:0]           data_q;
  logic [FW-1:0]           wdata_q;
  logic [31:0]             frame_cnt_q;
  logic                    clip_flag_q;
  logic [FW-1:0]           calc_data;
  logic [NUM_CH-1:0]       calc_sat;
  logic                    clip_set;

  // Per-channel datapath; operates on the frame captured at WAIT exit.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [CH_WIDTH-1:0] s_in;
    logic signed [PW-1:0]       prod;
    logic signed [PW-1:0]       shf;
    logic signed [CH_WIDTH-1:0] lvl_pos;
    logic signed [CH_WIDTH-1:0] lvl_neg;
    logic signed [CH_WIDTH-1:0] res;
    logic                       sat;

    assign s_in    = $signed(data_q[c*CH_WIDTH +: CH_WIDTH]);
    assign prod    = PW'(s_in) * PW'($signed({1'b0, gain_q}));
    assign shf     = prod >>> 6;
    assign lvl_pos = $signed({1'b0, clip_lvl_q});
    assign lvl_neg = -lvl_pos;

    always_comb begin
      res = s_in;
      sat = 1'b0;
      case (mode_q)
        MODE_GAIN: begin
          if (shf > SAT_MAX) begin
            res = SAT_MAX[CH_WIDTH-1:0];
            sat = 1'b1;
          end else if (shf < SAT_MIN) begin
            res = SAT_MIN[CH_WIDTH-1:0];
            sat = 1'b1;
          end else begin
            res = shf[CH_WIDTH-1:0];
          end
        end
        MODE_MUTE: res = '0;
        MODE_CLIP: begin
          if (s_in > lvl_pos) begin
            res = lvl_pos;
            sat = 1'b1;
          end else if (s_in < lvl_neg) begin
            res = lvl_neg;
            sat = 1'b1;
          end
        end
        default: ;
      endcase
    end

    assign calc_data[c*CH_WIDTH +: CH_WIDTH] = res;
    assign calc_sat[c] = sat;
  end

  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    adcfifo_read_o  = 1'b0;
    dacfifo_write_o = 1'b0;
    case (state_q)
      S_IDLE: if (en_i && !adcfifo_empty_i) state_d = S_RD;
      S_RD: begin
        adcfifo_read_o = 1'b1;
        wait_cnt_d     = '0;
        state_d        = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) state_d = S_CALC;
        else wait_cnt_d = wait_cnt_q + CW'(1);
      end
      S_CALC: state_d = S_WR;
      S_WR: begin
        if (!dacfifo_full_i) begin
          dacfifo_write_o = 1'b1;
          state_d         = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign clip_set = (state_q == S_CALC) && (|calc_sat);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      mode_q      <= '0;
      gain_q      <= '0;
      clip_lvl_q  <= '0;
      data_q      <= '0;
      wdata_q     <= '0;
      frame_cnt_q <= '0;
      clip_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (state_q == S_RD) begin
        mode_q     <= mode_i;
        gain_q     <= gain_i;
        clip_lvl_q <= clip_level_i;
      end
      if (state_q == S_WAIT && wait_cnt_q == WAIT_LAST) data_q <= adcfifo_readdata_i;
      if (state_q == S_CALC) wdata_q <= calc_data;
      if (dacfifo_write_o) frame_cnt_q <= frame_cnt_q + 32'd1;
      // A saturation in the same cycle as a clear keeps the flag set.
      if (clip_set) clip_flag_q <= 1'b1;
      else if (clip_clr_i) clip_flag_q <= 1'b0;
    end
  end

  assign dacfifo_writedata_o = wdata_q;
  assign frame_cnt_o         = frame_cnt_q;
  assign clip_flag_o         = clip_flag_q;
  assign busy_o              = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_audio_stream_proc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_audio_stream_proc: directed vector table plus multi-cycle sequences   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_audio_stream_proc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  gain = 8'd0;
  logic [14:0] clip_level = 15'd0;
  logic        clip_clr = 1'b0;
  logic        adc_empty = 1'b1;
  logic        adc_read;
  logic [31:0] adc_rdata = 32'hDEAD_BEEF;
  logic        dac_full = 1'b0;
  logic        dac_write;
  logic [31:0] dac_wdata;
  logic [31:0] frame_cnt;
  logic        clip_flag;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [31:0] rx_mem [64];
  int rx_wr = 0;
  int rx_rd = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int rd_empty_err = 0;
  int wr_full_err = 0;

  audio_stream_proc dut (
    .clk                 (clk),
    .reset               (reset),
    .en_i                (en),
    .mode_i              (mode),
    .gain_i              (gain),
    .clip_level_i        (clip_level),
    .clip_clr_i          (clip_clr),
    .adcfifo_empty_i     (adc_empty),
    .adcfifo_read_o      (adc_read),
    .adcfifo_readdata_i  (adc_rdata),
    .dacfifo_full_i      (dac_full),
    .dacfifo_write_o     (dac_write),
    .dacfifo_writedata_o (dac_wdata),
    .frame_cnt_o         (frame_cnt),
    .clip_flag_o         (clip_flag),
    .busy_o              (busy)
  );

  always #5 clk = ~clk;

  // rx FIFO model with one cycle read latency, and tx FIFO write monitor
  always @(posedge clk) begin
    if (adc_read) begin
      rd_cnt <= rd_cnt + 1;
      if (adc_empty) rd_empty_err <= rd_empty_err + 1;
      adc_rdata <= rx_mem[rx_rd % 64];
      rx_rd <= rx_rd + 1;
      adc_empty <= (rx_wr == rx_rd + 1);
    end else begin
      adc_empty <= (rx_wr == rx_rd);
    end
    if (dac_write) begin
      wr_cnt <= wr_cnt + 1;
      if (dac_full) wr_full_err <= wr_full_err + 1;
    end
  end

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  gain;
    logic [14:0] lvl;
    logic [31:0] din;
    logic [31:0] dout;
    logic        clip;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    rx_mem[rx_wr % 64] = d;
    rx_wr = rx_wr + 1;
  endtask

  task automatic run_frame(input logic [31:0] din, output bit ok);
    int start;
    @(negedge clk);
    push(din);
    en = 1'b1;
    start = wr_cnt;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (wr_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
    en = 1'b0;
  endtask

  task automatic start_and_wait_read(input logic [31:0] din, output bit ok);
    @(negedge clk);
    push(din);
    en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (adc_read) begin
        ok = 1'b1;
        break;
      end
    end
    en = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clip_clr = 1'b1;
    @(negedge clk);
    clip_clr = 1'b0;
  endtask

  initial begin
    bit ok;
    bit bad_wr, bad_data, bad_busy;
    int snap;

    vecs[0] = '{2'd0, 8'd0,   15'h0000, 32'h8001_7FFF, 32'h8001_7FFF, 1'b0};
    vecs[1] = '{2'd1, 8'd128, 15'h0000, 32'h9000_7000, 32'h8000_7FFF, 1'b1};
    vecs[2] = '{2'd1, 8'd32,  15'h0000, 32'hFF00_0100, 32'hFF80_0080, 1'b0};
    vecs[3] = '{2'd3, 8'd0,   15'h1000, 32'hE000_2000, 32'hF000_1000, 1'b1};
    vecs[4] = '{2'd1, 8'd64,  15'h0000, 32'h1234_8000, 32'h1234_8000, 1'b0};
    vecs[5] = '{2'd1, 8'd255, 15'h0000, 32'h0001_FFFF, 32'h0003_FFFC, 1'b0};
    vecs[6] = '{2'd2, 8'd64,  15'h0000, 32'h1234_5678, 32'h0000_0000, 1'b0};
    vecs[7] = '{2'd3, 8'd0,   15'h7FFF, 32'h8000_7FFF, 32'h8001_7FFF, 1'b1};
    vecs[8] = '{2'd3, 8'd0,   15'h0000, 32'h0000_0005, 32'h0000_0000, 1'b1};
    vecs[9] = '{2'd1, 8'd0,   15'h0000, 32'h8000_7FFF, 32'h0000_0000, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_read", adc_read, 0);
    check("rst_write", dac_write, 0);
    check("rst_wdata", dac_wdata, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_clip_flag", clip_flag, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      mode = vecs[i].mode;
      gain = vecs[i].gain;
      clip_level = vecs[i].lvl;
      run_frame(vecs[i].din, ok);
      check($sformatf("v%0d_done", i), ok, 1);
      check($sformatf("v%0d_data", i), dac_wdata, vecs[i].dout);
      check($sformatf("v%0d_clip", i), clip_flag, vecs[i].clip);
      check($sformatf("v%0d_cnt", i), frame_cnt, i + 1);
      pulse_clr();
      check($sformatf("v%0d_clr", i), clip_flag, 0);
    end

    // Clear and set in the same cycle: set wins.
    mode = 2'd3;
    clip_level = 15'h0010;
    start_and_wait_read(32'h0000_0100, ok);
    check("setwins_read", ok, 1);
    repeat (1 + 1) @(negedge clk);
    clip_clr = 1'b1;
    @(negedge clk);
    clip_clr = 1'b0;
    check("setwins_flag", clip_flag, 1);
    check("setwins_wr", dac_write, 1);
    @(negedge clk);
    check("setwins_data", dac_wdata, 32'h0000_0010);
    pulse_clr();

    // Inputs changed after RD must not affect the frame in flight.
    mode = 2'd0;
    gain = 8'd200;
    start_and_wait_read(32'h0000_0100, ok);
    check("latch_read", ok, 1);
    @(negedge clk);
    mode = 2'd2;
    gain = 8'd0;
    repeat (4) @(negedge clk);
    check("latch_data", dac_wdata, 32'h0000_0100);
    check("latch_cnt", frame_cnt, 12);

    // Backpressure: tx FIFO full for 10 cycles while in WR.
    dac_full = 1'b1;
    mode = 2'd1;
    gain = 8'd64;
    start_and_wait_read(32'h0AAA_0555, ok);
    check("bp_read", ok, 1);
    repeat (3) @(negedge clk);
    bad_wr = 1'b0;
    bad_data = 1'b0;
    bad_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (dac_write !== 1'b0) bad_wr = 1'b1;
      if (dac_wdata !== 32'h0AAA_0555) bad_data = 1'b1;
      if (busy !== 1'b1) bad_busy = 1'b1;
      @(negedge clk);
    end
    check("bp_no_write", bad_wr, 0);
    check("bp_data_stable", bad_data, 0);
    check("bp_busy", bad_busy, 0);
    snap = wr_cnt;
    dac_full = 1'b0;
    repeat (5) @(negedge clk);
    check("bp_one_write", wr_cnt - snap, 1);
    check("bp_cnt", frame_cnt, 13);

    // Reset while waiting for read data: frame discarded, nothing written.
    mode = 2'd0;
    start_and_wait_read(32'h1111_2222, ok);
    check("rstwait_read", ok, 1);
    snap = wr_cnt;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("rstwait_nowrite", wr_cnt - snap, 0);
    check("rstwait_cnt", frame_cnt, 0);
    check("rstwait_busy", busy, 0);
    check("rstwait_wdata", dac_wdata, 0);

    // Enabled with an empty rx FIFO: no read ever issued.
    snap = rd_cnt;
    en = 1'b1;
    repeat (20) @(negedge clk);
    en = 1'b0;
    check("empty_noread", rd_cnt - snap, 0);
    check("empty_busy", busy, 0);

    check("read_while_empty", rd_empty_err, 0);
    check("write_while_full", wr_full_err, 0);
    check("reads_eq_frames", rd_cnt, rx_wr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
